pellet_map_ctrl: RTL and testbench

//  Owns the single-port pellet map RAM and sequences every access to it. Loads the board

---
 rtl/pellet_map_ctrl.sv | 159 +++++++++++++++
 tb/tb_pellet_map_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pellet_map_ctrl.sv
// Pellet map RAM owner: loads the board from the layout ROM, arbitrates the
// single RAM port between video and Pac-Man eats, and tracks pellets and win.
module pellet_map_ctrl #(
    parameter int COLS = 28,
    parameter int ROWS = 30,
    parameter int AW   = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reload,
    output logic [AW-1:0] rom_addr,
    input  logic [1:0]    rom_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [1:0]    ram_wdata,
    input  logic [1:0]    ram_rdata,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    input  logic          eat_req,
    input  logic [4:0]    eat_col,
    input  logic [4:0]    eat_row,
    output logic          eat_ack,
    output logic [1:0]    eat_kind,
    output logic [9:0]    pellets_left,
    output logic          win,
    output logic          busy
);

    localparam int N  = COLS * ROWS;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_EAT_RD,
        S_EAT_CHK,
        S_EAT_WR
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [AW-1:0] eat_addr;
    logic [AW-1:0] eat_lin;
    logic          eat_bad;
    logic          cap_big;
    logic          restart;
    logic          dec;

    assign restart = reset | reload;
    assign busy    = (state == S_INIT);
    assign eat_bad = (int'(eat_col) >= COLS) || (int'(eat_row) >= ROWS);
    assign eat_lin = AW'(int'(eat_row) * COLS + int'(eat_col));

    always_ff @(posedge clk) begin
        if (restart) begin
            state <= S_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        rom_addr  = cnt[AW-1:0];
        ram_addr  = vid_addr;
        ram_we    = 1'b0;
        ram_wdata = 2'b01;
        eat_ack   = 1'b0;
        eat_kind  = 2'b00;
        dec       = 1'b0;
        unique case (state)
            S_INIT: begin
                // ROM data lags its address by one cycle, so the write trails cnt
                ram_addr  = AW'(cnt - CW'(1));
                ram_wdata = rom_data;
                ram_we    = (cnt != '0);
                if (cnt == CW'(N)) begin
                    state_nx = S_IDLE;
                end
            end
            S_IDLE: begin
                if (eat_req) begin
                    if (eat_bad || win) begin
                        eat_ack = 1'b1;
                    end else begin
                        state_nx = S_EAT_RD;
                    end
                end
            end
            S_EAT_RD: begin
                if (!vid_req) begin
                    ram_addr = eat_addr;
                    state_nx = S_EAT_CHK;
                end
            end
            S_EAT_CHK: begin
                if (!ram_rdata[0]) begin
                    state_nx = S_EAT_WR;
                end else begin
                    eat_ack  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_EAT_WR: begin
                if (!vid_req) begin
                    ram_addr = eat_addr;
                    ram_we   = 1'b1;
                    eat_ack  = 1'b1;
                    eat_kind = cap_big ? 2'b10 : 2'b01;
                    dec      = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_INIT;
        endcase
        // A restart abandons any eat in flight without acking or writing
        if (restart) begin
            ram_we   = 1'b0;
            eat_ack  = 1'b0;
            eat_kind = 2'b00;
            dec      = 1'b0;
            state_nx = S_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            cnt          <= '0;
            eat_addr     <= '0;
            cap_big      <= 1'b0;
            vid_valid    <= 1'b0;
            pellets_left <= '0;
            win          <= 1'b0;
        end else begin
            vid_valid <= vid_req && (state != S_INIT);
            if (state == S_INIT) begin
                cnt <= cnt + CW'(1);
                if ((cnt != '0) && !rom_data[0]) begin
                    pellets_left <= pellets_left + 10'd1;
                end
            end
            if ((state == S_IDLE) && eat_req && !eat_bad && !win) begin
                eat_addr <= eat_lin;
            end
            if (state == S_EAT_CHK) begin
                cap_big <= ram_rdata[1];
            end
            if (dec) begin
                pellets_left <= pellets_left - 10'd1;
                if (pellets_left == 10'd1) begin
                    win <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pellet_map_ctrl.sv
// Bench for pellet_map_ctrl: ROM/RAM models, a board-level reference model
// checked every cycle, and directed eat scenarios with literal expectations.
module tb_pellet_map_ctrl;

    localparam int COLS = 28;
    localparam int ROWS = 30;
    localparam int AW   = 10;
    localparam int N    = COLS * ROWS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          reload = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [1:0]    rom_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [1:0]    ram_wdata;
    logic [1:0]    ram_rdata;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_valid;
    logic          eat_req = 1'b0;
    logic [4:0]    eat_col = '0;
    logic [4:0]    eat_row = '0;
    logic          eat_ack;
    logic [1:0]    eat_kind;
    logic [9:0]    pellets_left;
    logic          win;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] rom   [0:1023];
    logic [1:0] ram   [0:1023];
    logic [1:0] snap  [0:1023];
    logic [1:0] board [0:1023];

    pellet_map_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk(clk), .reset(reset), .reload(reload),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
        .eat_req(eat_req), .eat_col(eat_col), .eat_row(eat_row),
        .eat_ack(eat_ack), .eat_kind(eat_kind),
        .pellets_left(pellets_left), .win(win), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: board contents, pellet count, win flag
    bit started = 0;
    int icnt = 0;
    int m_left = 0;
    bit m_win = 0;
    bit pv = 0;
    int pa = 0;

    always @(negedge clk) begin
        if (reset || reload) begin
            started = 1;
            icnt = 0;
            pv = 0;
            for (int a = 0; a < 1024; a++) snap[a] = rom[a];
        end else if (started) begin
            automatic bit busy_e = (icnt < N + 1);
            automatic int k_e = 0;
            automatic int a = int'(eat_row) * COLS + int'(eat_col);
            chk("busy", int'(busy), int'(busy_e));
            chk("vid_valid", int'(vid_valid), int'(pv));
            if (pv && vid_valid) chk("vid_data", int'(ram_rdata), int'(board[pa]));
            if (busy_e) begin
                chk("ack_in_init", int'(eat_ack), 0);
            end else begin
                chk("pellets_left", int'(pellets_left), m_left);
                chk("win", int'(win), int'(m_win));
                if (eat_ack) begin
                    if (eat_col < COLS && eat_row < ROWS && !m_win) begin
                        if (board[a] == 2'd0) k_e = 1;
                        if (board[a] == 2'd2) k_e = 2;
                    end
                    chk("eat_kind", int'(eat_kind), k_e);
                end
                chk("ram_we", int'(ram_we), int'(eat_ack && k_e != 0));
                if (ram_we) begin
                    chk("wr_addr", int'(ram_addr), a);
                    chk("wr_data", int'(ram_wdata), 1);
                end
                if (eat_ack && k_e != 0) begin
                    board[a] = 2'd1;
                    m_left--;
                    if (m_left == 0) m_win = 1;
                end
            end
            pv = vid_req && !busy_e;
            pa = int'(vid_addr);
            if (icnt == N) begin
                m_left = 0;
                m_win = 0;
                for (int i = 0; i < 1024; i++) begin
                    board[i] = snap[i];
                    if (i < N && (snap[i] == 2'd0 || snap[i] == 2'd2)) m_left++;
                end
            end
            if (icnt < N + 1) icnt++;
        end
    end

    task automatic build_std();
        int c = 0;
        for (int a = 0; a < 1024; a++) rom[a] = 2'd1;
        for (int r = 1; r < 29; r++)
            for (int q = 1; q < 27; q++)
                if (c < 240) begin
                    rom[r * COLS + q] = 2'd0;
                    c++;
                end
        rom[3 * COLS + 1]  = 2'd2;
        rom[3 * COLS + 26] = 2'd2;
        rom[N - 1] = 2'd3;
    endtask

    task automatic build_two();
        for (int a = 0; a < 1024; a++) rom[a] = 2'd1;
        rom[2 * COLS + 2] = 2'd0;
        rom[5 * COLS + 5] = 2'd0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        if (busy) chk("init_timeout", 1, 0);
    endtask

    task automatic do_eat(input int col, input int row, input int stall,
                          input int rl_at, output int lat, output int kind);
        lat = -1;
        kind = -1;
        eat_col = 5'(col);
        eat_row = 5'(row);
        eat_req = 1'b1;
        for (int k = 0; k < 40; k++) begin
            vid_req = (k >= 1 && k <= stall);
            vid_addr = 10'(k * 7);
            reload = (k == rl_at);
            @(negedge clk);
            if (eat_ack && lat < 0) begin
                lat = k;
                kind = int'(eat_kind);
            end
            @(posedge clk);
            #1;
            if (lat >= 0 || k == rl_at) break;
        end
        eat_req = 1'b0;
        vid_req = 1'b0;
        reload = 1'b0;
        if (lat < 0 && rl_at < 0) chk("eat_timeout", 1, 0);
    endtask

    task automatic do_reload(output int n);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        wait_init(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat, kind, errs;
        build_std();
        // T1: reset and load the standard board
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 1);
        chk("rst_left", int'(pellets_left), 0);
        chk("rst_win", int'(win), 0);
        chk("rst_vid_valid", int'(vid_valid), 0);
        chk("rst_ack", int'(eat_ack), 0);
        chk("rst_kind", int'(eat_kind), 0);
        chk("rst_we", int'(ram_we), 0);
        wait_init(n);
        chk("t1_busy_cycles", n + 1, 841);
        chk("t1_left", int'(pellets_left), 240);
        errs = 0;
        for (int a = 0; a < N; a++) if (ram[a] !== rom[a]) errs++;
        chk("t1_ram_eq_rom", errs, 0);
        @(posedge clk);
        #1;
        // video-only reads between eats
        for (int k = 0; k < 6; k++) begin
            vid_req = 1'b1;
            vid_addr = 10'(k * 29);
            @(posedge clk);
            #1;
        end
        vid_req = 1'b0;
        @(posedge clk);
        #1;
        // T2: small pellet
        do_eat(1, 1, 0, -1, lat, kind);
        chk("t2_lat", lat, 3);
        chk("t2_kind", kind, 1);
        chk("t2_left", int'(pellets_left), 239);
        chk("t2_ram29", int'(ram[29]), 1);
        // T3: big pellet with video stalling the read
        do_eat(1, 3, 5, -1, lat, kind);
        chk("t3_lat", lat, 8);
        chk("t3_kind", kind, 2);
        chk("t3_left", int'(pellets_left), 238);
        // T4: non-pellet eats
        do_eat(1, 1, 0, -1, lat, kind);
        chk("t4_reeat_lat", lat, 2);
        chk("t4_reeat_kind", kind, 0);
        do_eat(0, 0, 0, -1, lat, kind);
        chk("t4_wall_lat", lat, 2);
        chk("t4_wall_kind", kind, 0);
        do_eat(28, 0, 0, -1, lat, kind);
        chk("t4_oob_lat", lat, 0);
        chk("t4_oob_kind", kind, 0);
        do_eat(0, 30, 0, -1, lat, kind);
        chk("t4_oobrow_lat", lat, 0);
        chk("t4_left", int'(pellets_left), 238);
        // T5: two-pellet board, eat both for the win
        build_two();
        do_reload(n);
        chk("t5_busy_cycles", n, 841);
        chk("t5_left", int'(pellets_left), 2);
        do_eat(2, 2, 0, -1, lat, kind);
        chk("t5_kind1", kind, 1);
        chk("t5_win_early", int'(win), 0);
        do_eat(5, 5, 2, -1, lat, kind);
        chk("t5_kind2", kind, 1);
        chk("t5_left0", int'(pellets_left), 0);
        chk("t5_win", int'(win), 1);
        do_eat(2, 2, 0, -1, lat, kind);
        chk("t5_after_win_lat", lat, 0);
        chk("t5_after_win_kind", kind, 0);
        chk("t5_win_sticky", int'(win), 1);
        // T6: reload while the eat sits in its check cycle
        build_std();
        do_reload(n);
        chk("t6_left_init", int'(pellets_left), 240);
        chk("t6_win_clr", int'(win), 0);
        do_eat(0, 0, 0, 2, lat, kind);
        chk("t6_no_ack", lat, -1);
        @(negedge clk);
        chk("t6_busy", int'(busy), 1);
        wait_init(n);
        chk("t6_left", int'(pellets_left), 240);
        @(posedge clk);
        #1;
        do_eat(26, 3, 1, -1, lat, kind);
        chk("t6_post_kind", kind, 2);
        chk("t6_post_left", int'(pellets_left), 239);
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
